// File: rtl/out_port_uart_tx_if.sv
// CPU out_port handshake plus UART/FIFO status, shared by the CPU side and the UART sink.
interface out_port_uart_tx_if #(
    parameter int FIFO_DEPTH_LOG2 = 2
) ();
    logic [15:0]              din;
    logic                     din_valid;
    logic                     tx;
    logic                     busy;
    logic                     fifo_full;
    logic                     overflow;
    logic [FIFO_DEPTH_LOG2:0] level;

    modport master (output din, din_valid, input tx, busy, fifo_full, overflow, level);
    modport slave  (input din, din_valid, output tx, busy, fifo_full, overflow, level);
endinterface

// File: rtl/out_port_uart_tx.sv
// Buffers 16-bit CPU out_port words in a small FIFO and sends each word as two
// 8N1 UART bytes, low byte first.
module out_port_uart_tx #(
    parameter int CLKS_PER_BIT    = 16,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    out_port_uart_tx_if.slave bus
);
    localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0]        BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_DEPTH_LOG2:0] LEVEL_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                   state_reg, state_next;
    logic [BAUD_W-1:0]        baud_reg, baud_next;
    logic [2:0]               bit_idx_reg, bit_idx_next;
    logic                     byte_sel_reg, byte_sel_next;
    logic                     tx_reg, tx_next;
    logic [15:0]              hold_reg;
    logic [7:0]               cur_byte;

    logic [15:0]              mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_DEPTH_LOG2:0] level_reg, level_next;
    logic                     fifo_full_reg, overflow_reg;
    logic                     pop, push;

    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign pop  = (state_reg == IDLE) && (level_reg != '0);
    assign push = bus.din_valid && ((level_reg != LEVEL_FULL) || pop);

    always_comb begin
        level_next = level_reg;
        if (push && !pop)
            level_next = level_reg + 1'b1;
        else if (pop && !push)
            level_next = level_reg - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            fifo_full_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg     <= level_next;
            fifo_full_reg <= (level_next == LEVEL_FULL);
            if (bus.din_valid && !push)
                overflow_reg <= 1'b1;
        end
    end

    // Storage has no reset; the hold register doubles as the RAM's registered read port.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= bus.din;
        if (pop)
            hold_reg <= mem[rd_ptr_reg];
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte_mux
            assign cur_byte[gi] = byte_sel_reg ? hold_reg[8 + gi] : hold_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_idx_reg  <= '0;
            byte_sel_reg <= 1'b0;
            tx_reg       <= 1'b1;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_idx_reg  <= bit_idx_next;
            byte_sel_reg <= byte_sel_next;
            tx_reg       <= tx_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_next     = baud_reg;
        bit_idx_next  = bit_idx_reg;
        byte_sel_next = byte_sel_reg;
        tx_next       = 1'b1;
        case (state_reg)
            IDLE: begin
                baud_next    = '0;
                bit_idx_next = '0;
                if (pop) begin
                    state_next    = START;
                    byte_sel_next = 1'b0;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_reg == BAUD_LAST) begin
                    state_next   = DATA;
                    baud_next    = '0;
                    bit_idx_next = '0;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            DATA: begin
                tx_next = cur_byte[bit_idx_reg];
                if (baud_reg == BAUD_LAST) begin
                    baud_next = '0;
                    if (bit_idx_reg == 3'd7)
                        state_next = STOP;
                    else
                        bit_idx_next = bit_idx_reg + 1'b1;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            STOP: begin
                if (baud_reg == BAUD_LAST) begin
                    baud_next = '0;
                    // The high byte follows the low byte's stop bit with no idle gap.
                    if (!byte_sel_reg) begin
                        byte_sel_next = 1'b1;
                        state_next    = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.tx        = tx_reg;
    assign bus.busy      = (level_reg != '0) || (state_reg != IDLE);
    assign bus.fifo_full = fifo_full_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.level     = level_reg;
endmodule

// File: doc/out_port_uart_tx.md
Name: out_port_uart_tx

Overview:
Sink for the CPU's 16-bit output port. Each single-cycle output_valid strobe pushes the out_port word into a small FIFO. The block then drains the FIFO as two 8N1 UART bytes per word, low byte first, on a single serial line. It sits beside the CPU at top level and gives the core a non-blocking debug/console output.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit period; must be >= 2.
FIFO_DEPTH_LOG2, 2, log2 of FIFO depth in 16-bit words (default depth 4).

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  asynchronous, active-high reset.
din  input  16  word from CPU out_port.
din_valid  input  1  one-cycle strobe from CPU output_valid; din sampled on the same edge.
tx  output  1  UART serial line; idle high.
busy  output  1  high while the FIFO is non-empty or the FSM is not IDLE.
fifo_full  output  1  count == 2**FIFO_DEPTH_LOG2.
overflow  output  1  sticky; set when a strobe is dropped; cleared only by rst.
level  output  FIFO_DEPTH_LOG2+1  current FIFO word count.

Behaviour:
- Reset (async, while rst=1): tx=1, busy=0, fifo_full=0, overflow=0, level=0; FSM to IDLE; FIFO pointers 0; bit counter and baud counter 0; byte_sel=0. Reset mid-frame aborts the frame and tx goes high immediately.
- Push on every clk edge where din_valid=1:
  - Accepted if level < depth, or a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow <= 1.
  - Push+pop in the same cycle: level unchanged; data ordering is preserved.
- FIFO storage: circular buffer. Read/write pointers are FIFO_DEPTH_LOG2 bits and wrap naturally. level is tracked as a separate counter.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If level != 0, pop the head word into a 16-bit hold register, set byte_sel=0, go to START. The pop happens in the IDLE cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = current byte[bit index], LSB first. Each bit is held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if byte_sel=0, set byte_sel=1 and go to START (no gap between the two bytes of a word). Otherwise go to IDLE.
  - Current byte = hold[7:0] when byte_sel=0, hold[15:8] when byte_sel=1.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every state or bit change.
- Latency: a strobe at edge E into an empty FIFO with the FSM in IDLE gives a pop at edge E+1 and tx low starting after edge E+2 (registered tx).
- Word frame length: 20*CLKS_PER_BIT cycles. Back-to-back words have exactly one IDLE cycle (tx=1) between the high-byte stop bit and the next start bit.
- busy falls in the cycle after the last STOP ends, if the FIFO is empty.
- tx, fifo_full and level are registered outputs (no combinational path from din_valid); busy derives from registered state only.

Test Plan:
- Single word, CLKS_PER_BIT=4, din=16'hA55A:
  - tx low 2 cycles after the strobe, then 80 cycles of frame.
  - Sampled bits: 0,0,1,0,1,1,0,1,0,1 then 0,1,0,1,0,0,1,0,1,1.
  - busy falls after the frame; overflow=0.
- Burst of 6 strobes on consecutive cycles, words 1..6, depth 4:
  - level after strobes reads 1,1,2,3,4,4.
  - Word 6 is dropped; overflow=1.
  - Words 1..5 are transmitted in order with single idle cycles between them.
- Push while full and in the popping IDLE cycle:
  - Strobe lands in the same cycle as a pop at level=4.
  - Word accepted, level stays 4, overflow stays 0.
- FIFO wrap:
  - Push and drain 10 words (0x0000..0x0009) in groups of 3.
  - All received intact and in order across pointer wrap.
- Reset mid-frame:
  - Assert rst during DATA of the high byte.
  - tx=1 immediately; level=0, busy=0.
  - After release, a new word 0x1234 is transmitted correctly with no residue from the old frame.
- Overflow stickiness:
  - After an overflow, drain the FIFO fully: overflow remains 1.
  - Only rst clears it.
